tour_cmd: RTL

- Sits directly upstream of cmd_proc and muxes its command source.
- In idle it passes the UART_wrapper command stream through to cmd_proc unchanged.
- After a start_tour pulse it takes over. It reads the solved knight's-tour move list from TourLogic one move at a time, indexed by mv_indx.
- Each L-shaped knight move becomes two cmd_proc move commands: vertical leg first, then horizontal leg. Each leg is handshaked through clr_cmd_rdy and send_resp.

---
 rtl/tour_cmd.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/tour_cmd.sv
// Command-source mux in front of cmd_proc. It forwards UART commands while idle.
// During a knight's tour it issues one vertical leg and one horizontal leg per move.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | UART pass-through; waiting for start_tour
//   VERT   | presenting the vertical leg of move[mv_indx]; waiting for clr_cmd_rdy
//   WAIT_V | vertical leg accepted; waiting for send_resp
//   HORZ   | presenting the horizontal leg; waiting for clr_cmd_rdy
//   WAIT_H | horizontal leg accepted; waiting for send_resp, then next move
module tour_cmd #(
   parameter int NUM_MOVES = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [7:0]  resp
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VERT   = 3'd1,
      WAIT_V = 3'd2,
      HORZ   = 3'd3,
      WAIT_H = 3'd4
   } state_t;

   localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

   localparam logic [3:0] OP_MOVE    = 4'h2;
   localparam logic [3:0] OP_FANFARE = 4'h3;
   localparam logic [7:0] HDG_NORTH  = 8'h00;
   localparam logic [7:0] HDG_WEST   = 8'h3F;
   localparam logic [7:0] HDG_SOUTH  = 8'h7F;
   localparam logic [7:0] HDG_EAST   = 8'hBF;
   localparam logic [7:0] RESP_IDLE  = 8'hA5;
   localparam logic [7:0] RESP_TOUR  = 8'h5A;

   state_t      state;
   logic        move_vld;
   logic        dy_north;
   logic        dx_east;
   logic [3:0]  dy_mag;
   logic [3:0]  dx_mag;
   logic [15:0] vert_cmd;
   logic [15:0] horz_cmd;

   // Lowest set bit of the one-hot move wins, so a malformed multi-hot move still decodes.
   always_comb begin
      move_vld = |move;
      dy_north = 1'b0;
      dx_east  = 1'b0;
      dy_mag   = 4'd0;
      dx_mag   = 4'd0;
      if (move[0]) begin
         dy_north = 1'b1; dy_mag = 4'd2; dx_east = 1'b1; dx_mag = 4'd1;
      end else if (move[1]) begin
         dy_north = 1'b1; dy_mag = 4'd2; dx_east = 1'b0; dx_mag = 4'd1;
      end else if (move[2]) begin
         dy_north = 1'b0; dy_mag = 4'd1; dx_east = 1'b0; dx_mag = 4'd2;
      end else if (move[3]) begin
         dy_north = 1'b1; dy_mag = 4'd1; dx_east = 1'b0; dx_mag = 4'd2;
      end else if (move[4]) begin
         dy_north = 1'b0; dy_mag = 4'd2; dx_east = 1'b0; dx_mag = 4'd1;
      end else if (move[5]) begin
         dy_north = 1'b0; dy_mag = 4'd2; dx_east = 1'b1; dx_mag = 4'd1;
      end else if (move[6]) begin
         dy_north = 1'b1; dy_mag = 4'd1; dx_east = 1'b1; dx_mag = 4'd2;
      end else if (move[7]) begin
         dy_north = 1'b0; dy_mag = 4'd1; dx_east = 1'b1; dx_mag = 4'd2;
      end
   end

   assign vert_cmd = {OP_MOVE,    (dy_north ? HDG_NORTH : HDG_SOUTH), dy_mag};
   assign horz_cmd = {OP_FANFARE, (dx_east  ? HDG_EAST  : HDG_WEST),  dx_mag};

   // Outside IDLE the UART inputs never reach cmd/cmd_rdy.
   always_comb begin
      cmd     = 16'h0000;
      cmd_rdy = 1'b0;
      unique case (state)
         IDLE: begin
            cmd     = cmd_UART;
            cmd_rdy = cmd_rdy_UART;
         end
         VERT: begin
            cmd     = vert_cmd;
            cmd_rdy = move_vld;
         end
         WAIT_V: cmd = vert_cmd;
         HORZ: begin
            cmd     = horz_cmd;
            cmd_rdy = 1'b1;
         end
         WAIT_H: cmd = horz_cmd;
         default: begin
            cmd     = cmd_UART;
            cmd_rdy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mv_indx <= 5'd0;
         resp    <= RESP_IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_tour) begin
                  state   <= VERT;
                  mv_indx <= 5'd0;
                  resp    <= RESP_TOUR;
               end
            end
            VERT: begin
               // An empty move means TourLogic has nothing valid; give control back to UART.
               if (!move_vld) begin
                  state <= IDLE;
                  resp  <= RESP_IDLE;
               end else if (clr_cmd_rdy) begin
                  state <= WAIT_V;
               end
            end
            WAIT_V: begin
               if (send_resp) state <= HORZ;
            end
            HORZ: begin
               if (clr_cmd_rdy) state <= WAIT_H;
            end
            WAIT_H: begin
               if (send_resp) begin
                  if (mv_indx >= LAST_INDX) begin
                     state <= IDLE;
                     resp  <= RESP_IDLE;
                  end else begin
                     mv_indx <= mv_indx + 5'd1;
                     state   <= VERT;
                  end
               end
            end
            default: begin
               state <= IDLE;
               resp  <= RESP_IDLE;
            end
         endcase
      end
   end

endmodule
